// File: rtl/nes_mem_responder_pkg.sv
// nes_mem_responder_pkg
//   Shared types and constants for the NES memory responder: FSM state
//   encoding, CPU address width, region boundaries and the open-bus reset
//   value, plus small address-decode helpers.
package nes_mem_responder_pkg;

    localparam int MEM_ADDR_SIZE = 16;

    // 6502 NOP opcode; the bus floats to this value out of reset.
    localparam logic [7:0] NOP            = 8'hEA;
    localparam logic [7:0] OPEN_BUS_RESET = NOP;

    localparam logic [MEM_ADDR_SIZE-1:0] RAM_MIRROR_TOP = 16'h1FFF;
    localparam logic [MEM_ADDR_SIZE-1:0] ROM_BASE       = 16'h8000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_t;

    function automatic logic is_ram_addr(input logic [MEM_ADDR_SIZE-1:0] addr);
        return addr <= RAM_MIRROR_TOP;
    endfunction

    function automatic logic is_rom_addr(input logic [MEM_ADDR_SIZE-1:0] addr);
        return addr >= ROM_BASE;
    endfunction

endpackage

// File: rtl/nes_mem_responder_if.sv
// nes_mem_responder_if
//   CPU-side request/response bus of the memory responder.
//   master : CPU core (drives req_*, observes ready and response)
//   slave  : responder (drives req_ready_o, rsp_valid_o, rsp_rdata_o)
interface nes_mem_responder_if;
    import nes_mem_responder_pkg::*;

    logic                     req_valid_i;
    logic                     req_ready_o;
    logic                     req_we_i;
    logic [MEM_ADDR_SIZE-1:0] req_addr_i;
    logic [7:0]               req_wdata_i;
    logic                     rsp_valid_o;
    logic [7:0]               rsp_rdata_o;

    modport master (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o
    );

    modport slave (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o
    );

endinterface

// File: rtl/nes_mem_responder_byte_ram.sv
// nes_byte_ram
//   Single-port byte array with synchronous write and registered read.
//   Read data reflects the contents before a same-edge write.
//   clk     : clock
//   we_i    : write enable
//   addr_i  : byte index
//   wdata_i : write data
//   rdata_o : registered read data
module nes_byte_ram #(
    parameter int DEPTH = 2048,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [7:0]    wdata_i,
    output logic [7:0]    rdata_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
        rdata_q <= mem_q[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/nes_mem_responder.sv
// nes_mem_responder
//   Byte-wide memory responder for the CPU core. Decodes 2 KB RAM mirrored
//   over 0x0000-0x1FFF, cartridge ROM at 0x8000-0xFFFF and open bus
//   elsewhere; inserts WAIT_CYCLES wait states and returns one response
//   pulse per accepted request. ROM is filled through the preload port.
//   clk, rst      : clock, asynchronous active-high reset
//   bus           : request/response interface (slave side)
//   load_en_i     : ROM preload strobe (only honoured while idle)
//   load_addr_i   : ROM preload byte index
//   load_data_i   : ROM preload data
//   busy_o        : high whenever an access is in flight
module nes_mem_responder
    import nes_mem_responder_pkg::*;
#(
    parameter int RAM_BYTES   = 2048,
    parameter int ROM_BYTES   = 32768,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    nes_mem_responder_if.slave        bus,
    input  logic                      load_en_i,
    input  logic [14:0]               load_addr_i,
    input  logic [7:0]                load_data_i,
    output logic                      busy_o
);

    localparam int RAM_AW = $clog2(RAM_BYTES);
    localparam int ROM_AW = $clog2(ROM_BYTES);
    localparam int CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    mem_state_t               state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [7:0]               rsp_rdata_q;

    logic                     we_q;
    logic [MEM_ADDR_SIZE-1:0] addr_q;
    logic [7:0]               wdata_q;

    logic                     ready;
    logic                     accept;
    logic                     eff_we;
    logic [MEM_ADDR_SIZE-1:0] eff_addr;
    logic [7:0]               eff_wdata;
    logic                     ram_we, rom_we;
    logic [ROM_AW-1:0]        rom_addr;
    logic [7:0]               ram_rdata, rom_rdata;
    logic [7:0]               resp_data;

    assign accept = ready && bus.req_valid_i;

    // The memories are addressed from the live request in IDLE so that a
    // zero-wait access still has its read data registered by the accept edge.
    assign eff_we    = (state_q == IDLE) ? bus.req_we_i    : we_q;
    assign eff_addr  = (state_q == IDLE) ? bus.req_addr_i  : addr_q;
    assign eff_wdata = (state_q == IDLE) ? bus.req_wdata_i : wdata_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ready   = 1'b0;
        busy_o  = 1'b1;
        bus.rsp_valid_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                ready  = !load_en_i;
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                bus.rsp_valid_o = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready_o = ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rsp_rdata_q <= OPEN_BUS_RESET;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == RESP) begin
                rsp_rdata_q <= resp_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= bus.req_we_i;
            addr_q  <= bus.req_addr_i;
            wdata_q <= bus.req_wdata_i;
        end
    end

    // RAM commits on the edge that enters RESP; gating with rst keeps an
    // access aborted by reset from ever reaching the array.
    assign ram_we   = (state_d == RESP) && !rst && eff_we && is_ram_addr(eff_addr);
    assign rom_we   = (state_q == IDLE) && load_en_i;
    assign rom_addr = rom_we ? load_addr_i[ROM_AW-1:0] : eff_addr[ROM_AW-1:0];

    nes_byte_ram #(.DEPTH(RAM_BYTES)) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .addr_i  (eff_addr[RAM_AW-1:0]),
        .wdata_i (eff_wdata),
        .rdata_o (ram_rdata)
    );

    nes_byte_ram #(.DEPTH(ROM_BYTES)) u_rom (
        .clk     (clk),
        .we_i    (rom_we),
        .addr_i  (rom_addr),
        .wdata_i (load_data_i),
        .rdata_o (rom_rdata)
    );

    // Writes put their data on the bus; unmapped reads leave the last value.
    always_comb begin
        resp_data = rsp_rdata_q;
        if (we_q) begin
            resp_data = wdata_q;
        end else if (is_ram_addr(addr_q)) begin
            resp_data = ram_rdata;
        end else if (is_rom_addr(addr_q)) begin
            resp_data = rom_rdata;
        end
    end

    assign bus.rsp_rdata_o = (state_q == RESP) ? resp_data : rsp_rdata_q;

endmodule

// File: tb/tb_nes_mem_responder.sv
module tb_nes_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0;
    logic        load_en = 1'b0;
    logic [14:0] load_addr = '0;
    logic [7:0]  load_data = '0;
    logic        busy1, busy0, busy3;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    nes_mem_responder_if if1 ();
    nes_mem_responder_if if0 ();
    nes_mem_responder_if if3 ();

    assign if1.req_valid_i = req_valid;
    assign if1.req_we_i    = req_we;
    assign if1.req_addr_i  = req_addr;
    assign if1.req_wdata_i = req_wdata;
    assign if0.req_valid_i = req_valid;
    assign if0.req_we_i    = req_we;
    assign if0.req_addr_i  = req_addr;
    assign if0.req_wdata_i = req_wdata;
    assign if3.req_valid_i = req_valid;
    assign if3.req_we_i    = req_we;
    assign if3.req_addr_i  = req_addr;
    assign if3.req_wdata_i = req_wdata;

    nes_mem_responder #(.WAIT_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .bus(if1.slave), .load_en_i(load_en),
        .load_addr_i(load_addr), .load_data_i(load_data), .busy_o(busy1)
    );
    nes_mem_responder #(.WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .rst(rst), .bus(if0.slave), .load_en_i(load_en),
        .load_addr_i(load_addr), .load_data_i(load_data), .busy_o(busy0)
    );
    nes_mem_responder #(.WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .rst(rst), .bus(if3.slave), .load_en_i(load_en),
        .load_addr_i(load_addr), .load_data_i(load_data), .busy_o(busy3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Called at a falling edge with all responders idle; returns at a falling edge.
    task automatic preload(input logic [14:0] a, input logic [7:0] d);
        load_en = 1'b1; load_addr = a; load_data = d;
        #1;
        chk("preload ready low", 32'(if1.req_ready_o), 32'd0);
        @(negedge clk);
        load_en = 1'b0;
    endtask

    // Issues one request to all three responders and watches six cycles.
    task automatic access(input string tag, input logic we, input logic [15:0] a,
                          input logic [7:0] d, input logic [7:0] exp);
        int lat1, lat0, lat3, np1, np0, np3;
        logic [7:0] got;
        lat1 = 0; lat0 = 0; lat3 = 0; np1 = 0; np0 = 0; np3 = 0; got = 8'h00;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (if1.rsp_valid_o) begin np1++; if (lat1 == 0) begin lat1 = k; got = if1.rsp_rdata_o; end end
            if (if0.rsp_valid_o) begin np0++; if (lat0 == 0) lat0 = k; end
            if (if3.rsp_valid_o) begin np3++; if (lat3 == 0) lat3 = k; end
            if (k == 1) req_valid = 1'b0;
        end
        chk({tag, " data"},   32'(got),  32'(exp));
        chk({tag, " lat w1"}, 32'(lat1), 32'd2);
        chk({tag, " lat w0"}, 32'(lat0), 32'd1);
        chk({tag, " lat w3"}, 32'(lat3), 32'd4);
        chk({tag, " pulses w1"}, 32'(np1), 32'd1);
        chk({tag, " pulses w0"}, 32'(np0), 32'd1);
        chk({tag, " pulses w3"}, 32'(np3), 32'd1);
    endtask

    initial begin
        int acc1, acc0, acc3;

        // Reset and idle state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset rdata", 32'(if1.rsp_rdata_o), 32'h0000_00EA);
        chk("reset rsp_valid", 32'(if1.rsp_valid_o), 32'd0);
        chk("reset ready", 32'(if1.req_ready_o), 32'd1);
        chk("reset busy", 32'(busy1), 32'd0);
        @(negedge clk);

        // ROM preload and reads at both ends of the ROM window
        preload(15'h0000, 8'hA9);
        preload(15'h7FFF, 8'h4C);
        access("rd 8000", 1'b0, 16'h8000, 8'h00, 8'hA9);
        access("rd FFFF", 1'b0, 16'hFFFF, 8'h00, 8'h4C);

        // RAM write and mirrors
        access("wr 0002", 1'b1, 16'h0002, 8'h55, 8'h55);
        access("rd 0802", 1'b0, 16'h0802, 8'h00, 8'h55);
        access("rd 1002", 1'b0, 16'h1002, 8'h00, 8'h55);
        access("rd 1802", 1'b0, 16'h1802, 8'h00, 8'h55);

        // Open bus: unmapped reads return the last bus value
        access("rd 8000 again", 1'b0, 16'h8000, 8'h00, 8'hA9);
        access("rd 0002", 1'b0, 16'h0002, 8'h00, 8'h55);
        access("rd 4000 open", 1'b0, 16'h4000, 8'h00, 8'h55);
        access("rd 2000 open", 1'b0, 16'h2000, 8'h00, 8'h55);
        access("rd 7FFF open", 1'b0, 16'h7FFF, 8'h00, 8'h55);

        // Writes to ROM are dropped but still answered with the write data
        access("wr 8000", 1'b1, 16'h8000, 8'h99, 8'h99);
        access("rd 8000 kept", 1'b0, 16'h8000, 8'h00, 8'hA9);
        access("wr 4000 open", 1'b1, 16'h4000, 8'h3C, 8'h3C);

        // Throughput with req_valid held for 20 cycles
        acc1 = 0; acc0 = 0; acc3 = 0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 16'h8000;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (if1.req_ready_o) acc1++;
            if (if0.req_ready_o) acc0++;
            if (if3.req_ready_o) acc3++;
            @(negedge clk);
        end
        req_valid = 1'b0;
        chk("throughput w1", 32'(acc1), 32'd7);
        chk("throughput w0", 32'(acc0), 32'd10);
        chk("throughput w3", 32'(acc3), 32'd4);
        repeat (6) @(negedge clk);
        chk("drained busy w3", 32'(busy3), 32'd0);

        // Reset during the wait state of a RAM write
        access("wr 0010", 1'b1, 16'h0010, 8'h11, 8'h11);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 16'h0010; req_wdata = 8'h77;
        @(negedge clk);
        chk("abort busy in wait", 32'(busy1), 32'd1);
        chk("abort no early rsp", 32'(if1.rsp_valid_o), 32'd0);
        rst = 1'b1;
        req_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort rsp_valid", 32'(if1.rsp_valid_o), 32'd0);
        end
        rst = 1'b0;
        #1;
        chk("abort busy after", 32'(busy1), 32'd0);
        chk("abort rdata reset", 32'(if1.rsp_rdata_o), 32'h0000_00EA);
        @(negedge clk);
        access("rd 0010 after abort", 1'b0, 16'h0010, 8'h00, 8'h11);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
